// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcodes, register names and the ID/EX bundle type
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

package mips_pkg;

    localparam int ADDR_W = `ADDRESS_SIZE;
    localparam int DATA_W = `DATA_SIZE;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] next_pc;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] imm;
        logic [5:0]        opcode;
        logic [5:0]        funct;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        write_reg;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } id_ex_t;

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - 2R1W register file, r0 hardwired to zero; REGFILE_BYPASS_EN adds WB->read bypass
module regfile
    import mips_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && wr_addr != REG_ZERO && int'(wr_addr) < NUM_REGS) begin
            regs[wr_addr] <= wr_data;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [4:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (addr != REG_ZERO && int'(addr) < NUM_REGS) begin
            val = regs[addr];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr != REG_ZERO && wr_addr == addr) begin
            val = wr_data;
        end
`endif
        return val;
    endfunction

    always_comb begin
        rs_data = read_port(rs_addr);
        rt_data = read_port(rt_addr);
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS ID stage: decode, register file, load-use detect, ID/EX register (REGFILE_BYPASS_EN optional)
module decode_stage
    import mips_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ex_stall_c,
    input  logic              mem_stall_c,
    input  logic              EX_MEM_changePC_c,
    input  logic [ADDR_W-1:0] IF_ID_nextPC,
    input  logic [DATA_W-1:0] IF_ID_IR,
    input  logic              MEM_WB_regWrite_c,
    input  logic [4:0]        MEM_WB_writeReg,
    input  logic [DATA_W-1:0] MEM_WB_writeData,
    output logic              id_stall_c,
    output logic              ID_EX_valid,
    output logic [ADDR_W-1:0] ID_EX_nextPC,
    output logic [DATA_W-1:0] ID_EX_A,
    output logic [DATA_W-1:0] ID_EX_B,
    output logic [DATA_W-1:0] ID_EX_imm,
    output logic [5:0]        ID_EX_opcode,
    output logic [5:0]        ID_EX_funct,
    output logic [4:0]        ID_EX_rs,
    output logic [4:0]        ID_EX_rt,
    output logic [4:0]        ID_EX_writeReg,
    output logic              ID_EX_regWrite_c,
    output logic              ID_EX_memRead_c,
    output logic              ID_EX_memWrite_c
);

    id_ex_t            id_ex;
    id_ex_t            dec;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm16;
    logic              uses_rs;
    logic              uses_rt;
    logic              unused_shamt;

    assign opcode       = IF_ID_IR[31:26];
    assign rs           = IF_ID_IR[25:21];
    assign rt           = IF_ID_IR[20:16];
    assign rd           = IF_ID_IR[15:11];
    assign imm16        = IF_ID_IR[15:0];
    assign unused_shamt = ^IF_ID_IR[10:6];

    regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
        .clock   (clock),
        .reset   (reset),
        .rs_addr (rs),
        .rt_addr (rt),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .wr_en   (MEM_WB_regWrite_c),
        .wr_addr (MEM_WB_writeReg),
        .wr_data (MEM_WB_writeData)
    );

    always_comb begin
        dec           = '0;
        dec.valid     = 1'b1;
        dec.next_pc   = IF_ID_nextPC;
        dec.a         = rs_data;
        dec.b         = rt_data;
        dec.imm       = {{(DATA_W-16){imm16[15]}}, imm16};
        dec.opcode    = opcode;
        dec.funct     = IF_ID_IR[5:0];
        dec.rs        = rs;
        dec.rt        = rt;
        case (opcode)
            OP_RTYPE: begin
                dec.reg_write = 1'b1;
                dec.write_reg = rd;
            end
            OP_LW: begin
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
                dec.write_reg = rt;
            end
            OP_SW: dec.mem_write = 1'b1;
            OP_ADDI, OP_SLTI: begin
                dec.reg_write = 1'b1;
                dec.write_reg = rt;
            end
            OP_ANDI, OP_ORI: begin
                dec.reg_write = 1'b1;
                dec.write_reg = rt;
                dec.imm       = {{(DATA_W-16){1'b0}}, imm16};
            end
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.write_reg = rt;
                dec.imm       = DATA_W'({imm16, 16'b0});
            end
            OP_JAL: begin
                dec.reg_write = 1'b1;
                dec.write_reg = REG_RA;
            end
            default: ;
        endcase
        if (dec.write_reg == REG_ZERO) begin
            dec.reg_write = 1'b0;
        end
    end

    // Only registered ID/EX state and IF/ID feed the stall, keeping it off the WB path.
    always_comb begin
        uses_rs    = !(opcode == OP_J || opcode == OP_JAL || opcode == OP_LUI);
        uses_rt    = (opcode == OP_RTYPE || opcode == OP_BEQ ||
                      opcode == OP_BNE   || opcode == OP_SW);
        id_stall_c = id_ex.valid && id_ex.mem_read && (id_ex.write_reg != REG_ZERO) &&
                     ((uses_rs && id_ex.write_reg == rs) || (uses_rt && id_ex.write_reg == rt)) &&
                     !EX_MEM_changePC_c;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id_ex <= '0;
        end else if (EX_MEM_changePC_c) begin
            id_ex <= '0;
        end else if (ex_stall_c || mem_stall_c) begin
            id_ex <= id_ex;
        end else if (id_stall_c) begin
            id_ex <= '0;
        end else begin
            id_ex <= dec;
        end
    end

    assign ID_EX_valid      = id_ex.valid;
    assign ID_EX_nextPC     = id_ex.next_pc;
    assign ID_EX_A          = id_ex.a;
    assign ID_EX_B          = id_ex.b;
    assign ID_EX_imm        = id_ex.imm;
    assign ID_EX_opcode     = id_ex.opcode;
    assign ID_EX_funct      = id_ex.funct;
    assign ID_EX_rs         = id_ex.rs;
    assign ID_EX_rt         = id_ex.rt;
    assign ID_EX_writeReg   = id_ex.write_reg;
    assign ID_EX_regWrite_c = id_ex.reg_write;
    assign ID_EX_memRead_c  = id_ex.mem_read;
    assign ID_EX_memWrite_c = id_ex.mem_write;

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the 5-stage MIPS pipeline: consumes the IF/ID pipeline register (`IF_ID_nextPC`, `IF_ID_IR`) and produces the registered ID/EX bundle for execute. It contains the 32×32 register file, which the writeback stage writes, and the load-use hazard detector. The detector drives `id_stall_c` back to fetch, so fetch holds IF/ID while this block inserts a bubble.

## Interface
Parameters:
- `NUM_REGS`, default 32: register-file depth. Register index width is fixed at 5.

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `ex_stall_c`, `mem_stall_c`  in  1 each  downstream stall; hold ID/EX
- `EX_MEM_changePC_c`  in  1  redirect resolved; squash the instruction in ID
- `IF_ID_nextPC`  in  `ADDRESS_SIZE`  PC+4 of the instruction in ID
- `IF_ID_IR`  in  `DATA_SIZE`  instruction word
- `MEM_WB_regWrite_c`  in  1  writeback enable
- `MEM_WB_writeReg`  in  5  writeback destination
- `MEM_WB_writeData`  in  `DATA_SIZE`  writeback value
- `id_stall_c`  out  1  load-use stall (combinational)
- `ID_EX_valid`  out  1  slot holds a real instruction
- `ID_EX_nextPC`  out  `ADDRESS_SIZE`
- `ID_EX_A`, `ID_EX_B`  out  `DATA_SIZE`  rs/rt read values
- `ID_EX_imm`  out  `DATA_SIZE`  extended immediate
- `ID_EX_opcode`, `ID_EX_funct`  out  6 each
- `ID_EX_rs`, `ID_EX_rt`, `ID_EX_writeReg`  out  5 each
- `ID_EX_regWrite_c`, `ID_EX_memRead_c`, `ID_EX_memWrite_c`  out  1 each

## Operation
Decode, by opcode:
- R-type (0x00): `regWrite`=1, `writeReg`=rd.
- LW (0x23): `memRead`=1, `regWrite`=1, `writeReg`=rt.
- SW (0x2B): `memWrite`=1.
- ADDI 0x08, SLTI 0x0A, ANDI 0x0C, ORI 0x0D, LUI 0x0F: `regWrite`=1, `writeReg`=rt.
- BEQ 0x04, BNE 0x05, J 0x02: no write.
- JAL 0x03: `regWrite`=1, `writeReg`=31.
- Any other opcode decodes as a NOP: all control bits 0, `ID_EX_valid`=1.
- If the resolved `writeReg`=0, `regWrite` is forced to 0.

Immediate:
- ANDI/ORI: zero-extend `IR[15:0]`.
- LUI: `{IR[15:0],16'b0}`.
- All others: sign-extend.

Register file:
- Reads of r0 return 0.
- Write on the rising edge when `MEM_WB_regWrite_c` and `MEM_WB_writeReg`≠0.

Hazard detection:
- Uses rs: every opcode except J, JAL, LUI.
- Uses rt: R-type, BEQ, BNE, SW.
- `id_stall_c` = `ID_EX_valid` & `ID_EX_memRead_c` & `ID_EX_writeReg`≠0 & (`writeReg` matches a used rs or rt) & !`EX_MEM_changePC_c`.

ID/EX update, in priority order:
1. `reset`: all outputs 0, `ID_EX_valid`=0, register file cleared.
2. `EX_MEM_changePC_c`: load a bubble (`valid` and all control bits 0; data fields don't-care, implemented as 0).
3. `ex_stall_c` | `mem_stall_c`: hold every ID/EX field.
4. `id_stall_c`: load a bubble. Fetch holds IF/ID, so the instruction re-decodes next cycle.
5. Otherwise: load the decoded IF/ID contents.

## Timing
- Latency is one cycle, IF/ID to ID/EX.
- `id_stall_c` depends only on IF/ID and ID/EX registers, never on WB inputs, so there is no combinational loop with fetch.
- A load-use stall lasts exactly one cycle; the bubble clears `ID_EX_memRead_c`.
- Register-file write takes effect at the edge. Same-cycle read behaviour is set by the macro below.
- Reset asserted mid-operation clears state immediately (asynchronous). The first valid decode occurs on the first edge after deassertion.

## Configuration
- `REGFILE_BYPASS_EN` defined: a read whose index equals `MEM_WB_writeReg` while `MEM_WB_regWrite_c`=1 (index≠0) returns `MEM_WB_writeData` in the same cycle.
- Undefined: the read returns the pre-write register contents. Execute-stage forwarding must then cover the WB→ID distance.

## Structure
- Shared package `mips_pkg`:
  - opcode/funct constants
  - `REG_ZERO`, `REG_RA` (31)
  - `id_ex_t` struct for the ID/EX bundle
- Widths come from `defines.vh` (`ADDRESS_SIZE`, `DATA_SIZE`).
- Sub-module `regfile`: 2 read ports, 1 write port, async reset, optional bypass.

## Test plan
- Reset, then `IF_ID_IR`=0x2008_0005 (ADDI r8,r0,5), `nextPC`=0x4 → next cycle: `ID_EX_valid`=1, `imm`=5, `writeReg`=8, `regWrite`=1, `nextPC`=0x4.
- WB writes r9=0xDEAD_BEEF, then `IR`=0x0129_5020 (ADD r10,r9,r9) → `ID_EX_A`=`ID_EX_B`=0xDEAD_BEEF. Writing r0=0x1234 then reading r0 → 0.
- LW r8,0(r4) followed by ADD r10,r8,r9 → `id_stall_c`=1 for one cycle, ID/EX holds a bubble (`valid`=0), ADD decodes on the next edge. SW r8 with rs≠8 as consumer also stalls. BEQ with rt≠8 and rs≠8 does not stall.
- `EX_MEM_changePC_c`=1 simultaneous with a load-use match → `id_stall_c`=0, ID/EX bubble. `ex_stall_c`=1 for 3 cycles → all ID/EX outputs unchanged.
- ORI 0x3508_8000 → `imm`=0x0000_8000. ADDI with imm 0x8000 → `imm`=0xFFFF_8000. JAL → `writeReg`=31. Opcode 0x3F → `valid`=1, all control 0.
- Same-cycle WB write r5=0x77 and read r5: with `REGFILE_BYPASS_EN` → 0x77; without → the old value.
